// File: rtl/param_delay_line.sv
// Programmable sample delay line: circular history buffer, fill-gated valid, clamped runtime delay.
// Latency = active delay D in accepted samples; in_valid=0 freezes everything, no backpressure.
module param_delay_line #(
    parameter int WIDTH       = 8,
    parameter int MAX_DEPTH   = 32,
    parameter int RESET_DELAY = 30,
    localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             in_valid,
    input  logic [DW-1:0]    delay,
    input  logic             delay_load,
    input  logic             flush,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [DW-1:0]    fill_level
);
    localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(MAX_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(MAX_DEPTH - 1);
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] ONE_D   = DW'(1);

    typedef enum logic [1:0] {EMPTY, FILLING, RUNNING} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [MAX_DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    back;
    logic [PW-1:0]    rd_ptr;
    logic [DW-1:0]    d;
    logic [DW-1:0]    new_d;
    logic [DW-1:0]    next_fill;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en;
    logic             restart;

    always_comb begin
        new_d = delay;
        if (delay == '0)
            new_d = ONE_D;
        else if (delay > MAX_D)
            new_d = MAX_D;
        // The sample D-1 advances back; D-1 < MAX_DEPTH so it is never overwritten yet.
        back   = PW'(d - ONE_D);
        rd_ptr = wptr - back;
        if (wptr < back)
            rd_ptr = wptr - back + DEPTH_P;
        rd_data   = (d == ONE_D) ? data : mem[rd_ptr];
        next_fill = (state == RUNNING) ? d : fill_level + ONE_D;
        restart   = flush | delay_load;
        wr_en     = in_valid & ~flush;
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wptr] <= data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out        <= '0;
            out_valid  <= 1'b0;
            fill_level <= '0;
            d          <= DW'(RESET_DELAY);
            wptr       <= '0;
        end else begin
            if (wr_en)
                wptr <= (wptr == LAST_P) ? '0 : wptr + PW'(1);
            if (restart) begin
                if (delay_load)
                    d <= new_d;
                out       <= '0;
                out_valid <= 1'b0;
                if (wr_en) begin
                    // Only reachable with delay_load and no flush: this sample is advance 0.
                    fill_level <= ONE_D;
                    if (new_d == ONE_D) begin
                        state     <= RUNNING;
                        out       <= data;
                        out_valid <= 1'b1;
                    end else begin
                        state <= FILLING;
                    end
                end else begin
                    state      <= EMPTY;
                    fill_level <= '0;
                end
            end else if (in_valid) begin
                fill_level <= next_fill;
                case (state)
                    EMPTY, FILLING: begin
                        if (next_fill == d) begin
                            state     <= RUNNING;
                            out       <= rd_data;
                            out_valid <= 1'b1;
                        end else begin
                            state <= FILLING;
                        end
                    end
                    RUNNING: out <= rd_data;
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_param_delay_line.sv
// Bench for param_delay_line: directed scenarios plus random traffic against a queue-based model.
module tb_param_delay_line;
    localparam int WIDTH = 8;
    localparam int MAXD  = 32;
    localparam int RDLY  = 30;
    localparam int DW    = $clog2(MAXD + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data = '0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    delay = '0;
    logic             delay_load = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [DW-1:0]    fill_level;

    int checks = 0;
    int failures = 0;

    // Reference: accepted samples since restart; output is the one D-1 positions back.
    logic [WIDTH-1:0] hist[$];
    int               m_d;
    int               m_cnt;
    logic [WIDTH-1:0] m_out;
    logic             m_vld;
    int               m_fill;

    param_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .RESET_DELAY(RDLY)) dut (
        .clock(clock), .reset(reset), .data(data), .in_valid(in_valid),
        .delay(delay), .delay_load(delay_load), .flush(flush),
        .out(out), .out_valid(out_valid), .fill_level(fill_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_d = RDLY; m_cnt = 0; m_out = '0; m_vld = 1'b0; m_fill = 0;
    endtask

    task automatic model_edge(input logic [WIDTH-1:0] dt, input logic v, input int dl,
                              input logic ld, input logic fl);
        bit adv;
        if (ld || fl) begin
            if (ld) m_d = (dl == 0) ? 1 : (dl > MAXD ? MAXD : dl);
            hist.delete();
            m_cnt = 0;
            adv = v && !fl;
        end else begin
            adv = v;
        end
        if (ld || fl || adv) begin
            if (adv) begin
                hist.push_back(dt);
                m_cnt++;
                if (hist.size() > 64) void'(hist.pop_front());
            end
            m_fill = (m_cnt < m_d) ? m_cnt : m_d;
            if (m_cnt >= m_d) begin
                m_vld = 1'b1;
                m_out = hist[hist.size() - m_d];
            end else begin
                m_vld = 1'b0;
                m_out = '0;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".out"}, 32'(out), 32'(m_out));
        check({tag, ".vld"}, 32'(out_valid), 32'(m_vld));
        check({tag, ".fill"}, 32'(fill_level), 32'(m_fill));
    endtask

    // Called at a falling edge: drive, clock, update model, check at next falling edge.
    task automatic step(input string tag, input logic [WIDTH-1:0] dt, input logic v,
                        input int dl, input logic ld, input logic fl);
        data = dt; in_valid = v; delay = DW'(dl); delay_load = ld; flush = fl;
        @(posedge clock);
        model_edge(dt, v, dl, ld, fl);
        @(negedge clock);
        check_outs(tag);
        in_valid = 1'b0; delay_load = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int sawd;
        model_reset();
        #1;
        check_outs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Stream from reset at D=30: valid first on advance 29 carrying 0x01.
        for (int i = 0; i < 45; i++) begin
            step("stream30", WIDTH'(i + 1), 1'b1, 0, 1'b0, 1'b0);
            if (i == 28) check("first_valid29", 32'(out_valid), 32'd0);
            if (i == 29) check("first_out30", 32'(out), 32'h01);
        end

        step("load1", 8'hA5, 1'b1, 1, 1'b1, 1'b0);
        check("load1_direct", 32'(out), 32'hA5);
        for (int i = 0; i < 5; i++) step("d1run", 8'($urandom), 1'b1, 0, 1'b0, 1'b0);

        step("load0", 8'h3C, 1'b1, 0, 1'b1, 1'b0);
        check("load0_clamp", 32'(out_valid), 32'd1);

        // Oversized request clamps to 32; 100 samples wrap the pointer several times.
        step("load40", 8'h00, 1'b0, 40, 1'b1, 1'b0);
        sawd = -1;
        for (int i = 0; i < 100; i++) begin
            step("d32", WIDTH'(i + 7), 1'b1, 0, 1'b0, 1'b0);
            if (out_valid && sawd < 0) sawd = i;
        end
        check("d32_first_adv", 32'(sawd), 32'd31);

        // D=4 with in_valid toggling: holds on idle cycles.
        step("load4", 8'h00, 1'b0, 4, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++)
            step("d4tog", 8'($urandom), 1'(i % 2 == 0), 0, 1'b0, 1'b0);

        step("flush55", 8'h55, 1'b1, 0, 1'b0, 1'b1);
        check("flush_fill", 32'(fill_level), 32'd0);
        for (int i = 0; i < 6; i++) step("postflush", 8'($urandom), 1'b1, 0, 1'b0, 1'b0);

        step("ldfl", 8'h77, 1'b1, 3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("postldfl", 8'($urandom), 1'b1, 0, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outs("async_rst");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step("refill", 8'($urandom), 1'b1, 0, 1'b0, 1'b0);
            if (i == 28) check("refill29", 32'(out_valid), 32'd0);
            if (i == 29) check("refill30", 32'(out_valid), 32'd1);
        end

        for (int i = 0; i < 1500; i++) begin
            logic ld, fl;
            ld = ($urandom_range(0, 39) == 0);
            fl = ($urandom_range(0, 59) == 0);
            step("rand", 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 40)), ld, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/param_delay_line.md
PARAM_DELAY_LINE -- requirements
Module: param_delay_line

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the data word width in bits (>=1).
REQ-002: Parameter MAX_DEPTH, default 32, SHALL set the largest supported delay in samples (>=2).
REQ-003: Parameter RESET_DELAY, default 30, SHALL set the active delay after reset (1..MAX_DEPTH).
REQ-004: Derived width DW SHALL be ceil(log2(MAX_DEPTH+1)).
REQ-005: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006: reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007: data  input  WIDTH  SHALL be the sample to accept.
REQ-008: in_valid  input  1  SHALL be the advance strobe; data is accepted on each rising edge where it is 1.
REQ-009: delay  input  DW  SHALL be the requested delay, sampled only when delay_load=1.
REQ-010: delay_load  input  1  SHALL request a change of the active delay.
REQ-011: flush  input  1  SHALL discard all buffered history.
REQ-012: out  output  WIDTH  SHALL be the registered delayed sample.
REQ-013: out_valid  output  1  SHALL flag that out holds a sample delayed by exactly the active delay.
REQ-014: fill_level  output  DW  SHALL report accepted samples since the last restart, saturating at the active delay.

Function
REQ-015: Active delay D SHALL be a register; the loaded value SHALL be clamped: 0 -> 1, >MAX_DEPTH -> MAX_DEPTH.
REQ-016: Advance n (n = 0,1,2... counting accepted samples since restart) SHALL set out, after that edge, to the sample accepted on advance n-D+1; D=1 SHALL behave as a single register.
REQ-017: Cycles with in_valid=0 SHALL hold out, out_valid, fill_level and the history unchanged.
REQ-018: History storage SHALL be a circular buffer with a write pointer wrapping MAX_DEPTH-1 -> 0; no shift-register of MAX_DEPTH stages.
REQ-019: State machine SHALL have states EMPTY (fill_level=0), FILLING (0<fill_level<D) and RUNNING (fill_level=D).
REQ-020: EMPTY -> FILLING (or -> RUNNING when D=1) on an advance; FILLING -> RUNNING on the advance that makes fill_level reach D; RUNNING SHALL persist across advances.
REQ-021: out_valid SHALL be 1 exactly when the state is RUNNING; out SHALL be 0 whenever out_valid=0.
REQ-022: delay_load SHALL, on that edge, latch the clamped delay into D and restart filling: state -> EMPTY, fill_level -> 0, out_valid -> 0, out -> 0.
REQ-023: delay_load with in_valid=1 on the same edge SHALL write the sample and count it as advance 0 of the new fill (fill_level=1; RUNNING if new D=1).
REQ-024: flush SHALL behave as delay_load without changing D; flush with in_valid SHALL discard that sample (fill_level=0).
REQ-025: flush and delay_load together SHALL latch the new D and discard any simultaneous sample.
REQ-026: Buffer contents SHALL never be cleared on restart; stale entries SHALL never reach out, guaranteed by the fill gating.
REQ-027: The write pointer SHALL continue across restarts without being reset.

Reset
REQ-028: Asserting reset SHALL immediately force out=0, out_valid=0, fill_level=0, state EMPTY, D=RESET_DELAY, and write pointer=0.
REQ-029: Buffer storage SHALL need no reset.
REQ-030: The first edge after reset release SHALL be a normal operating edge.

Verification (WIDTH=8, MAX_DEPTH=32, RESET_DELAY=30)
REQ-031: After reset, stream 0x01,0x02,... with in_valid=1 every cycle -> out_valid rises on advance 29 with out=0x01, then out tracks input minus 29; fill_level holds at 30.
REQ-032: delay_load with delay=1 plus data=0xA5 -> out=0xA5, out_valid=1 after that edge.
REQ-033: delay_load with delay=0 -> D=1; with delay=40 -> D=32, with the first valid output on advance 31 and correct data across pointer wrap over 100 samples.
REQ-034: RUNNING at D=4 with in_valid toggling 1/0 -> out changes only on in_valid=1 edges, always the sample from 3 advances earlier.
REQ-035: flush asserted together with in_valid (data=0x55) in RUNNING -> out=0, out_valid=0, fill_level=0; 0x55 never appears on out.
REQ-036: Reset asserted mid-stream, asynchronously between edges -> outputs zero immediately; after release, D=30 and refill takes 30 advances.
